// File: rtl/imem_arbiter.sv
// imem_arbiter
// Shares one single-port, synchronous-read instruction memory between the
// core fetch unit (read-only) and the program loader / debug port (read or
// write). One access is granted per cycle; read data returns one cycle after
// the grant with a valid strobe routed to whichever requester owns it.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   if_req/if_addr        fetch read request (held until if_gnt)
//   if_gnt                fetch accepted this cycle
//   if_rvalid/if_rdata    fetch read return
//   ld_req/ld_we/ld_addr/ld_wdata  loader request (held until ld_gnt)
//   ld_lock               loader exclusive mode, fetch never granted
//   ld_gnt                loader accepted this cycle (also write completion)
//   ld_rvalid/ld_rdata    loader read return
//   mem_a/mem_w/mem_d     memory address, write enable, write data
//   mem_q                 registered memory read data
module imem_arbiter #(
    parameter int ADDR       = 16,
    parameter int WORD       = 32,
    parameter int MAX_LD_RUN = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [ADDR-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [WORD-1:0] if_rdata,
    input  logic            ld_req,
    input  logic            ld_we,
    input  logic [ADDR-1:0] ld_addr,
    input  logic [WORD-1:0] ld_wdata,
    input  logic            ld_lock,
    output logic            ld_gnt,
    output logic            ld_rvalid,
    output logic [WORD-1:0] ld_rdata,
    output logic [ADDR-1:0] mem_a,
    output logic            mem_w,
    output logic [WORD-1:0] mem_d,
    input  logic [WORD-1:0] mem_q
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2
    } owner_t;

    localparam logic [3:0] RUN_MAX = 4'(MAX_LD_RUN);

    owner_t          rd_owner_p1;
    owner_t          rd_owner_nxt;
    logic [3:0]      run_cnt;
    logic [3:0]      run_cnt_nxt;
    logic [ADDR-1:0] a_hold;
    logic            run_full;

    assign run_full = (run_cnt == RUN_MAX);

    // Grant: loader by default; fetch only when the loader is idle or has
    // used up its run budget while fetch was waiting. Nothing during reset.
    always_comb begin
        if_gnt = 1'b0;
        ld_gnt = 1'b0;
        if (!rst) begin
            if (ld_lock) begin
                ld_gnt = ld_req;
            end else if (if_req && (!ld_req || run_full)) begin
                if_gnt = 1'b1;
            end else begin
                ld_gnt = ld_req;
            end
        end
    end

    // Address holds its last driven value on idle cycles to avoid toggling
    // the memory address pins.
    always_comb begin
        mem_a = a_hold;
        if (if_gnt) begin
            mem_a = if_addr;
        end else if (ld_gnt) begin
            mem_a = ld_addr;
        end
    end

    assign mem_w = ld_gnt & ld_we;
    assign mem_d = ld_wdata;

    // The run counter only measures loader grants that actually made fetch
    // wait; lock mode keeps it at zero so unlocking restarts a fresh budget.
    always_comb begin
        run_cnt_nxt = run_cnt;
        if (ld_lock || if_gnt || !if_req) begin
            run_cnt_nxt = 4'd0;
        end else if (ld_gnt && !run_full) begin
            run_cnt_nxt = run_cnt + 4'd1;
        end
    end

    always_comb begin
        rd_owner_nxt = OWN_NONE;
        if (if_gnt) begin
            rd_owner_nxt = OWN_IF;
        end else if (ld_gnt && !ld_we) begin
            rd_owner_nxt = OWN_LD;
        end
    end

    // Stage p1: owner of the read whose data appears on mem_q next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner_p1 <= OWN_NONE;
            run_cnt     <= 4'd0;
            a_hold      <= '0;
        end else begin
            rd_owner_p1 <= rd_owner_nxt;
            run_cnt     <= run_cnt_nxt;
            a_hold      <= mem_a;
        end
    end

    // Strobes are masked while rst is high so a read granted just before
    // reset never reports data.
    assign if_rvalid = !rst && (rd_owner_p1 == OWN_IF);
    assign ld_rvalid = !rst && (rd_owner_p1 == OWN_LD);
    assign if_rdata  = mem_q;
    assign ld_rdata  = mem_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: directed scenarios followed by randomized
// traffic, all checked every cycle against a rule-level reference model.
module tb_imem_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ld_req;
    logic        ld_we;
    logic [15:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_lock;
    logic        ld_gnt;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic [15:0] mem_a;
    logic        mem_w;
    logic [31:0] mem_d;
    logic [31:0] mem_q;

    always #5 clk = ~clk;

    imem_arbiter #(.ADDR(16), .WORD(32), .MAX_LD_RUN(MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_lock(ld_lock), .ld_gnt(ld_gnt),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_a(mem_a), .mem_w(mem_w), .mem_d(mem_d), .mem_q(mem_q)
    );

    // Instruction memory: 16 words, address aliased on the low 4 bits.
    // Read data only updates on non-write cycles.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (mem_w) mem[mem_a[3:0]] <= mem_d;
        else       mem_q <= mem[mem_a[3:0]];
    end

    // Reference model state
    logic [31:0] sh [16];
    int          cnt = 0;
    int          p_owner = 0;   // 0 none, 1 fetch, 2 loader
    logic [31:0] p_data = '0;
    logic [15:0] a_hold = '0;
    bit          ahold_known = 0;
    bit          g_if = 0, g_ld = 0;

    int          n_vec = 0;
    int          n_bad = 0;
    int          n_ifg = 0, n_ldg = 0;
    logic        o_ldv, o_ifg;
    logic [31:0] o_ldd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic        e_if, e_ld, v_if, v_ld;
        logic [15:0] e_a;
        #3;
        if (rst) begin
            e_if = 1'b0; e_ld = 1'b0;
        end else if (ld_lock) begin
            e_if = 1'b0; e_ld = ld_req;
        end else begin
            e_if = if_req && (!ld_req || cnt == MAX);
            e_ld = ld_req && !e_if;
        end
        e_a  = e_if ? if_addr : (e_ld ? ld_addr : a_hold);
        v_if = !rst && p_owner == 1;
        v_ld = !rst && p_owner == 2;
        chk("if_gnt", 32'(if_gnt), 32'(e_if));
        chk("ld_gnt", 32'(ld_gnt), 32'(e_ld));
        chk("mem_w", 32'(mem_w), 32'(e_ld && ld_we));
        if (ahold_known) chk("mem_a", 32'(mem_a), 32'(e_a));
        if (e_ld && ld_we) chk("mem_d", mem_d, ld_wdata);
        chk("if_rvalid", 32'(if_rvalid), 32'(v_if));
        chk("ld_rvalid", 32'(ld_rvalid), 32'(v_ld));
        if (v_if) chk("if_rdata", if_rdata, p_data);
        if (v_ld) chk("ld_rdata", ld_rdata, p_data);
        n_ifg += int'(if_gnt);
        n_ldg += int'(ld_gnt);
        o_ifg = if_gnt;
        o_ldv = ld_rvalid;
        o_ldd = ld_rdata;
        @(posedge clk);
        #1;
        if (rst) begin
            cnt = 0; p_owner = 0; a_hold = '0; ahold_known = 1;
        end else begin
            p_owner = e_if ? 1 : ((e_ld && !ld_we) ? 2 : 0);
            p_data  = e_if ? sh[if_addr[3:0]] : sh[ld_addr[3:0]];
            if (e_ld && ld_we) sh[ld_addr[3:0]] = ld_wdata;
            a_hold = e_a;
            if (ld_lock || e_if || !if_req) cnt = 0;
            else if (e_ld)                  cnt = (cnt + 1 > MAX) ? MAX : cnt + 1;
        end
        g_if = e_if;
        g_ld = e_ld;
    endtask

    initial begin
        int mask, base_if, base_ld;
        bit found;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; ld_req = 1'b0; ld_we = 1'b0;
        ld_addr = '0; ld_wdata = '0; ld_lock = 1'b0;

        // Reset state
        tick(); tick();
        rst = 1'b0;

        // Preload memory through the loader port
        for (int i = 0; i < 16; i++) begin
            ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'(i); ld_wdata = $urandom;
            tick();
        end
        ld_req = 1'b0;

        // Fetch only, consecutive addresses
        for (int i = 0; i < 4; i++) begin
            if_req = 1'b1; if_addr = 16'(i);
            tick();
        end
        if_req = 1'b0;
        tick();

        // Loader write then readback
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0010; ld_wdata = 32'hDEADBEEF;
        tick();
        ld_we = 1'b0;
        tick();
        ld_req = 1'b0;
        tick();
        chk("wb_rvalid", 32'(o_ldv), 32'd1);
        chk("wb_data", o_ldd, 32'hDEADBEEF);

        // Contention: both requesting continuously
        mask = 0;
        if_req = 1'b1; if_addr = 16'($urandom);
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'($urandom);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (o_ifg) mask |= (1 << i);
            if (g_if) if_addr = 16'($urandom);
            if (g_ld) ld_addr = 16'($urandom);
        end
        chk("contention_pattern", 32'(mask), 32'h0000_4210);
        if_req = 1'b0; ld_req = 1'b0;
        tick();

        // Lock mode: fetch starves
        base_if = n_ifg; base_ld = n_ldg;
        ld_lock = 1'b1; if_req = 1'b1; ld_req = 1'b1; ld_we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (g_ld) ld_addr = 16'($urandom);
        end
        chk("lock_ld_gnts", 32'(n_ldg - base_ld), 32'd20);
        chk("lock_if_gnts", 32'(n_ifg - base_if), 32'd0);
        ld_lock = 1'b0;
        found = 0;
        for (int i = 0; i < MAX + 1 && !found; i++) begin
            tick();
            if (o_ifg) found = 1;
            if (g_ld) ld_addr = 16'($urandom);
        end
        chk("unlock_if_gnt", 32'(found), 32'd1);
        if_req = 1'b0; ld_req = 1'b0;
        tick();

        // Reset mid-read with a pending loader write
        if_req = 1'b1; if_addr = 16'h0005;
        tick();
        if_req = 1'b0;
        rst = 1'b1; ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0003; ld_wdata = 32'h1234_5678;
        tick(); tick();
        rst = 1'b0;
        tick();
        ld_req = 1'b0;
        tick();

        // Idle
        for (int i = 0; i < 5; i++) tick();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (!if_req || g_if) begin
                if_req = ($urandom % 4) != 0; if_addr = 16'($urandom);
            end
            if (!ld_req || g_ld) begin
                ld_req = ($urandom % 3) != 0; ld_we = 1'($urandom % 2);
                ld_addr = 16'($urandom); ld_wdata = $urandom;
            end
            if (($urandom % 20) == 0) ld_lock = ~ld_lock;
            rst = ($urandom % 50) == 0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-requester arbiter and sequencer for the single-port instruction memory (synchronous read, one access per cycle, write-or-read, registered read data). Shares the memory between the core's fetch unit (read-only) and the program loader/debug port (read or write). Sits between those two requesters and the instruction memory instance, driving its address, write-enable and write-data pins and routing its registered output back with a valid strobe.

## Interface
- ADDR, 16: instruction memory address width.
- WORD, 32: instruction word width.
- MAX_LD_RUN, 4: maximum consecutive loader grants while fetch is waiting (1..15).

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  if_rdata valid this cycle.
- if_rdata  out  WORD  fetch read data.
- ld_req  in  1  loader request; held with ld_we/ld_addr/ld_wdata stable until ld_gnt.
- ld_we  in  1  1 = write, 0 = read.
- ld_addr  in  ADDR  loader address.
- ld_wdata  in  WORD  loader write data.
- ld_lock  in  1  loader exclusive mode (core halted for program load).
- ld_gnt  out  1  loader request accepted this cycle.
- ld_rvalid  out  1  ld_rdata valid this cycle.
- ld_rdata  out  WORD  loader read data.
- mem_a  out  ADDR  to memory A.
- mem_w  out  1  to memory W.
- mem_d  out  WORD  to memory D.
- mem_q  in  WORD  from memory Q.

## Operation
- Grant is combinational from requests and registered state; at most one of if_gnt/ld_gnt per cycle.
- Priority: ld_lock=1 -> loader only; if_gnt held 0 regardless of if_req.
- Otherwise loader wins by default, except when run counter == MAX_LD_RUN and if_req=1: fetch wins that cycle.
- Run counter (4 bits): +1 on each ld_gnt while if_req=1 (saturate at MAX_LD_RUN); cleared on any if_gnt or any cycle with if_req=0; cleared on rst. Not advanced under ld_lock.
- Memory drive: granted requester's address on mem_a; mem_w = ld_gnt & ld_we; mem_d = ld_wdata. No grant -> mem_w=0, mem_a = last driven value (registered hold), mem_d don't-care.
- Read-return tracking: register rd_owner ∈ {NONE, IF, LD}, set at clock edge to IF on if_gnt, LD on ld_gnt & ~ld_we, else NONE.
- if_rvalid = (rd_owner==IF); ld_rvalid = (rd_owner==LD); if_rdata = ld_rdata = mem_q (unqualified when rvalid=0).
- Writes produce no rvalid; ld_gnt is the write completion.
- Address/data widths pass through unchanged; no truncation or extension.

## Timing
- Read latency: grant in cycle t -> rvalid and data in cycle t+1; exactly one rvalid pulse per read grant.
- Back-to-back: one grant per cycle sustained; reads from alternating owners return in grant order, one per cycle.
- Write in cycle t: memory updated at end of t; read of same address granted in t+1 returns new data in t+2.
- Write-then-read hazard: mem_q holds its previous value during write cycles; rd_owner=NONE so no strobe.
- Requesters must not drop req or change address/data before gnt; behaviour otherwise undefined.
- Simultaneous if_req & ld_req with counter < MAX_LD_RUN: ld_gnt=1, if_gnt=0.
- ld_lock asserted with fetch waiting: fetch starves indefinitely by design; counter held at 0.
- ld_lock deasserted: arbitration resumes next cycle with counter 0.
- Reset values: rd_owner=NONE, run counter=0, mem_a=0; during rst cycle if_gnt=ld_gnt=0, mem_w=0, if_rvalid=ld_rvalid=0.
- Reset mid-operation: a read granted in the cycle before rst rises has its rvalid suppressed (rd_owner cleared); requests pending during rst are not granted until the first cycle after rst falls.

## Test plan
- Fetch only: if_req with addresses 0,1,2,3 on consecutive cycles (preloaded memory) -> if_gnt each cycle, if_rvalid on cycles t+1..t+4 with words at 0..3, ld_* strobes 0.
- Loader write/readback: write 0xDEADBEEF to 0x0010, then read 0x0010 -> ld_gnt both cycles, mem_w=1 only the first, ld_rvalid one cycle after the read grant with 0xDEADBEEF.
- Contention with MAX_LD_RUN=4: if_req and ld_req both held high -> grant pattern LD,LD,LD,LD,IF repeating; each if_rvalid returns fetch data, not loader data.
- ld_lock: lock high with both requesting for 20 cycles -> 20 ld_gnt, zero if_gnt; unlock -> if_gnt within MAX_LD_RUN+1 cycles.
- Reset mid-read: fetch read granted at cycle t, rst high at t+1 -> if_rvalid=0 at t+1, mem_w=0, no grants until rst low, counter 0 afterwards.
- Idle: no requests for 5 cycles -> mem_w=0, mem_a held at last address, no rvalid.
